// File: rtl/logic_vector_sweeper_pkg.sv
// Shared encodings and sizes for the exhaustive 4-input vector sweeper.
package logic_vector_sweeper_pkg;

  localparam int unsigned NUM_VECTORS = 16;
  localparam int unsigned VEC_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/logic_vector_sweeper_sweep_hold_timer.sv
// Per-vector settle counter; tc_o is registered and high while the count sits at HOLD_CYCLES-1.
module sweep_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned HOLD_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              tc_q, tc_d;

  // Terminal flag is computed from the next count so it lines up with cnt_q.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_q ? '0 : cnt_q + HOLD_W'(1);
    end
    tc_d = (cnt_d == HOLD_W'(HOLD_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= (HOLD_CYCLES == 32'd1);
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/logic_vector_sweeper.sv
// Drives all 16 {a,b,c,d} vectors in order, holds each for HOLD_CYCLES, and
// captures the two returned outputs into truth-table registers.
module logic_vector_sweeper
  import logic_vector_sweeper_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned HOLD_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   out1_in,
  input  logic                   out2_in,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   d,
  output logic [VEC_W-1:0]       vec_idx,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VECTORS-1:0] tt_out1,
  output logic [NUM_VECTORS-1:0] tt_out2
);

  state_e                 state_q, state_d;
  logic [VEC_W-1:0]       vec_q, vec_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_VECTORS-1:0] tt1_q, tt1_d;
  logic [NUM_VECTORS-1:0] tt2_q, tt2_d;
  logic                   tmr_clr, tmr_en, tmr_tc;

  sweep_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .HOLD_W      (HOLD_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tt1_d   = tt1_q;
    tt2_d   = tt2_q;
    tmr_clr = 1'b1;
    tmr_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_DRIVE;
          vec_d   = '0;
          tt1_d   = '0;
          tt2_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_DRIVE: begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b1;
        // Abort beats a coincident capture so a partial table never gains a bit late.
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          tt1_d[vec_q] = out1_in;
          tt2_d[vec_q] = out2_in;
          if (vec_q == VEC_W'(NUM_VECTORS - 1)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d = vec_q + VEC_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt1_q   <= '0;
      tt2_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt1_q   <= tt1_d;
      tt2_q   <= tt2_d;
    end
  end

  assign {a, b, c, d} = vec_q;
  assign vec_idx      = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign tt_out1      = tt1_q;
  assign tt_out2      = tt2_q;

endmodule
